// File: rtl/game_sequencer.sv
// Tilt-maze game controller: start countdown, play gating, hole respawn,
// lives bookkeeping and best completion time.
module game_sequencer #(
  parameter int TICK_DIV       = 100_000_000,
  parameter int COUNTDOWN_SECS = 3,
  parameter int LIVES          = 3,
  parameter int FALL_SECS      = 2,
  parameter int RESULT_SECS    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic [3:0]  move_in,
  input  logic        won_the_game,
  input  logic        hit_a_hole,
  input  logic [15:0] elapsed,
  output logic [3:0]  move_out,
  output logic        ball_reset,
  output logic        timer_run,
  output logic        timer_clear,
  output logic [1:0]  lives,
  output logic [3:0]  count_digit,
  output logic [2:0]  state_out,
  output logic [15:0] best_time,
  output logic        new_best
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_FALL      = 3'd3,
    S_WON       = 3'd4,
    S_GAMEOVER  = 3'd5
  } state_t;

  state_t         state_reg, state_next;
  logic           start_q_reg;
  logic           start;
  logic [TW-1:0]  tick_cnt_reg;
  logic [7:0]     sec_cnt_reg;
  logic           tick;
  logic           state_change;

  logic [3:0]     move_out_reg;
  logic           ball_reset_reg;
  logic           timer_run_reg;
  logic           timer_clear_reg;
  logic [1:0]     lives_reg;
  logic [3:0]     count_digit_reg;
  logic [15:0]    best_time_reg;
  logic           new_best_reg;

  assign start        = start_btn & ~start_q_reg;
  assign tick         = (tick_cnt_reg == TW'(TICK_DIV - 1));
  assign state_change = (state_next != state_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_COUNTDOWN;
      end
      S_COUNTDOWN: begin
        if (tick && count_digit_reg <= 4'd1) state_next = S_PLAY;
      end
      S_PLAY: begin
        // A win on the same cycle as a hole counts as a win.
        if (won_the_game)
          state_next = S_WON;
        else if (hit_a_hole)
          state_next = (lives_reg > 2'd1) ? S_FALL : S_GAMEOVER;
      end
      S_FALL: begin
        if (tick && sec_cnt_reg == 8'(FALL_SECS - 1)) state_next = S_COUNTDOWN;
      end
      S_WON, S_GAMEOVER: begin
        if (tick && sec_cnt_reg == 8'(RESULT_SECS - 1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      // Track the button during reset so a held button is not seen as an edge.
      start_q_reg     <= start_btn;
      tick_cnt_reg    <= '0;
      sec_cnt_reg     <= '0;
      move_out_reg    <= '0;
      ball_reset_reg  <= 1'b1;
      timer_run_reg   <= 1'b0;
      timer_clear_reg <= 1'b0;
      lives_reg       <= '0;
      count_digit_reg <= '0;
      best_time_reg   <= 16'hFFFF;
      new_best_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      start_q_reg <= start_btn;

      if (state_change) begin
        tick_cnt_reg <= '0;
        sec_cnt_reg  <= '0;
      end else if (tick) begin
        tick_cnt_reg <= '0;
        sec_cnt_reg  <= sec_cnt_reg + 8'd1;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + TW'(1);
      end

      move_out_reg    <= move_in & {4{state_reg == S_PLAY}};
      ball_reset_reg  <= (state_next == S_IDLE) || (state_next == S_COUNTDOWN) ||
                         (state_next == S_GAMEOVER);
      timer_run_reg   <= (state_next == S_PLAY);
      timer_clear_reg <= (state_reg == S_IDLE) && (state_next == S_COUNTDOWN);
      new_best_reg    <= 1'b0;

      if (state_reg == S_IDLE && state_next == S_COUNTDOWN)
        lives_reg <= 2'(LIVES);
      else if (state_reg == S_PLAY && state_next == S_FALL)
        lives_reg <= lives_reg - 2'd1;
      else if (state_reg == S_PLAY && state_next == S_GAMEOVER)
        lives_reg <= 2'd0;

      if (state_next == S_COUNTDOWN && state_reg != S_COUNTDOWN)
        count_digit_reg <= 4'(COUNTDOWN_SECS);
      else if (state_reg == S_COUNTDOWN && tick)
        count_digit_reg <= count_digit_reg - 4'd1;
      else if (state_reg != S_COUNTDOWN)
        count_digit_reg <= 4'd0;

      if (state_reg == S_PLAY && state_next == S_WON && elapsed < best_time_reg) begin
        best_time_reg <= elapsed;
        new_best_reg  <= 1'b1;
      end
    end
  end

  assign move_out    = move_out_reg;
  assign ball_reset  = ball_reset_reg;
  assign timer_run   = timer_run_reg;
  assign timer_clear = timer_clear_reg;
  assign lives       = lives_reg;
  assign count_digit = count_digit_reg;
  assign state_out   = state_reg;
  assign best_time   = best_time_reg;
  assign new_best    = new_best_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short ticks (TICK_DIV=4).
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn;
  logic [3:0]  move_in;
  logic        won_the_game;
  logic        hit_a_hole;
  logic [15:0] elapsed;
  logic [3:0]  move_out;
  logic        ball_reset;
  logic        timer_run;
  logic        timer_clear;
  logic [1:0]  lives;
  logic [3:0]  count_digit;
  logic [2:0]  state_out;
  logic [15:0] best_time;
  logic        new_best;

  int checks = 0;
  int errors = 0;

  game_sequencer #(
    .TICK_DIV(4), .COUNTDOWN_SECS(3), .LIVES(3), .FALL_SECS(2), .RESULT_SECS(5)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .move_in(move_in),
    .won_the_game(won_the_game), .hit_a_hole(hit_a_hole), .elapsed(elapsed),
    .move_out(move_out), .ball_reset(ball_reset), .timer_run(timer_run),
    .timer_clear(timer_clear), .lives(lives), .count_digit(count_digit),
    .state_out(state_out), .best_time(best_time), .new_best(new_best)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Rising start edge from IDLE, then run the 12-cycle countdown into PLAY.
  task automatic start_game(input string tag);
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(12);
    checks++;
    if (state_out !== 3'd2) begin
      errors++;
      $display("FAIL %s_reach_play state got=%0d exp=2", tag, state_out);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(3);
    checks++;
    if (state_out !== 3'd0 || lives !== 2'd0 || count_digit !== 4'd0 || move_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_core state=%0d lives=%0d count=%0d move=%b exp 0/0/0/0000",
               state_out, lives, count_digit, move_out);
    end
    checks++;
    if (timer_run !== 1'b0 || timer_clear !== 1'b0 || new_best !== 1'b0 || best_time !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_timer run=%b clr=%b nb=%b best=%h exp 0/0/0/ffff",
               timer_run, timer_clear, new_best, best_time);
    end
    reset = 1'b0;
    step(2);
    checks++;
    if (state_out !== 3'd0 || ball_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle state=%0d ball_reset=%b exp 0/1", state_out, ball_reset);
    end
    $display("test_reset done");
  endtask

  task automatic test_start;
    start_btn = 1'b1;
    step(1);
    checks++;
    if (state_out !== 3'd1 || timer_clear !== 1'b1 || lives !== 2'd3 || count_digit !== 4'd3) begin
      errors++;
      $display("FAIL start_entry state=%0d clr=%b lives=%0d count=%0d exp 1/1/3/3",
               state_out, timer_clear, lives, count_digit);
    end
    move_in = 4'b0101;
    step(1);
    move_in = 4'b0000;
    start_btn = 1'b0;
    checks++;
    if (timer_clear !== 1'b0 || move_out !== 4'b0000 || ball_reset !== 1'b1) begin
      errors++;
      $display("FAIL start_pulse clr=%b move=%b ball_reset=%b exp 0/0000/1",
               timer_clear, move_out, ball_reset);
    end
    for (int i = 2; i <= 12; i++) begin
      checks++;
      if (count_digit !== 4'(3 - (i - 1) / 4) || state_out !== 3'd1) begin
        errors++;
        $display("FAIL countdown_%0d count=%0d state=%0d exp %0d/1",
                 i, count_digit, state_out, 3 - (i - 1) / 4);
      end
      step(1);
    end
    checks++;
    if (state_out !== 3'd2 || timer_run !== 1'b1 || ball_reset !== 1'b0 || count_digit !== 4'd0) begin
      errors++;
      $display("FAIL play_entry state=%0d run=%b ball_reset=%b count=%0d exp 2/1/0/0",
               state_out, timer_run, ball_reset, count_digit);
    end
    $display("test_start done");
  endtask

  task automatic test_move;
    move_in = 4'b0101;
    step(1);
    checks++;
    if (move_out !== 4'b0101) begin
      errors++;
      $display("FAIL move_0101 got=%b exp=0101", move_out);
    end
    move_in = 4'b1010;
    step(1);
    checks++;
    if (move_out !== 4'b1010) begin
      errors++;
      $display("FAIL move_1010 got=%b exp=1010", move_out);
    end
    move_in = 4'b0000;
    step(1);
    checks++;
    if (move_out !== 4'b0000) begin
      errors++;
      $display("FAIL move_idle got=%b exp=0000", move_out);
    end
    $display("test_move done");
  endtask

  task automatic test_holes;
    hit_a_hole = 1'b1;
    step(1);
    hit_a_hole = 1'b0;
    checks++;
    if (state_out !== 3'd3 || lives !== 2'd2 || timer_run !== 1'b0 || ball_reset !== 1'b0) begin
      errors++;
      $display("FAIL hole1 state=%0d lives=%0d run=%b ball_reset=%b exp 3/2/0/0",
               state_out, lives, timer_run, ball_reset);
    end
    move_in = 4'b0101;
    step(1);
    move_in = 4'b0000;
    checks++;
    if (move_out !== 4'b0000) begin
      errors++;
      $display("FAIL move_in_fall got=%b exp=0000", move_out);
    end
    step(6);
    checks++;
    if (state_out !== 3'd3) begin
      errors++;
      $display("FAIL fall_hold state=%0d exp=3", state_out);
    end
    step(1);
    checks++;
    if (state_out !== 3'd1 || count_digit !== 4'd3 || timer_clear !== 1'b0) begin
      errors++;
      $display("FAIL respawn state=%0d count=%0d clr=%b exp 1/3/0",
               state_out, count_digit, timer_clear);
    end
    step(12);
    checks++;
    if (state_out !== 3'd2) begin
      errors++;
      $display("FAIL replay1 state=%0d exp=2", state_out);
    end
    hit_a_hole = 1'b1;
    step(1);
    hit_a_hole = 1'b0;
    checks++;
    if (state_out !== 3'd3 || lives !== 2'd1) begin
      errors++;
      $display("FAIL hole2 state=%0d lives=%0d exp 3/1", state_out, lives);
    end
    step(8);
    checks++;
    if (state_out !== 3'd1) begin
      errors++;
      $display("FAIL respawn2 state=%0d exp=1", state_out);
    end
    step(12);
    hit_a_hole = 1'b1;
    step(1);
    hit_a_hole = 1'b0;
    checks++;
    if (state_out !== 3'd5 || lives !== 2'd0 || ball_reset !== 1'b1 || timer_run !== 1'b0) begin
      errors++;
      $display("FAIL gameover state=%0d lives=%0d ball_reset=%b run=%b exp 5/0/1/0",
               state_out, lives, ball_reset, timer_run);
    end
    step(19);
    checks++;
    if (state_out !== 3'd5) begin
      errors++;
      $display("FAIL gameover_hold state=%0d exp=5", state_out);
    end
    step(1);
    checks++;
    if (state_out !== 3'd0 || lives !== 2'd0) begin
      errors++;
      $display("FAIL gameover_idle state=%0d lives=%0d exp 0/0", state_out, lives);
    end
    $display("test_holes done");
  endtask

  task automatic test_win;
    start_game("win1");
    elapsed = 16'd100;
    won_the_game = 1'b1;
    step(1);
    won_the_game = 1'b0;
    checks++;
    if (state_out !== 3'd4 || best_time !== 16'd100 || new_best !== 1'b1 || ball_reset !== 1'b0) begin
      errors++;
      $display("FAIL win1 state=%0d best=%0d nb=%b ball_reset=%b exp 4/100/1/0",
               state_out, best_time, new_best, ball_reset);
    end
    step(1);
    checks++;
    if (new_best !== 1'b0 || best_time !== 16'd100 || lives !== 2'd3) begin
      errors++;
      $display("FAIL win1_pulse nb=%b best=%0d lives=%0d exp 0/100/3", new_best, best_time, lives);
    end
    step(18);
    checks++;
    if (state_out !== 3'd4) begin
      errors++;
      $display("FAIL won_hold state=%0d exp=4", state_out);
    end
    step(1);
    checks++;
    if (state_out !== 3'd0 || lives !== 2'd3) begin
      errors++;
      $display("FAIL won_idle state=%0d lives=%0d exp 0/3", state_out, lives);
    end
    start_game("win2");
    elapsed = 16'd120;
    won_the_game = 1'b1;
    step(1);
    won_the_game = 1'b0;
    checks++;
    if (state_out !== 3'd4 || best_time !== 16'd100 || new_best !== 1'b0) begin
      errors++;
      $display("FAIL win2 state=%0d best=%0d nb=%b exp 4/100/0", state_out, best_time, new_best);
    end
    step(20);
    $display("test_win done");
  endtask

  task automatic test_simultaneous;
    start_game("simul");
    elapsed = 16'd150;
    won_the_game = 1'b1;
    hit_a_hole = 1'b1;
    step(1);
    won_the_game = 1'b0;
    hit_a_hole = 1'b0;
    checks++;
    if (state_out !== 3'd4 || lives !== 2'd3 || best_time !== 16'd100 || new_best !== 1'b0) begin
      errors++;
      $display("FAIL simul state=%0d lives=%0d best=%0d nb=%b exp 4/3/100/0",
               state_out, lives, best_time, new_best);
    end
    step(20);
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid;
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(4);
    reset = 1'b1;
    step(1);
    checks++;
    if (state_out !== 3'd0 || count_digit !== 4'd0 || lives !== 2'd0 ||
        best_time !== 16'hFFFF || ball_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_countdown state=%0d count=%0d lives=%0d best=%h ball_reset=%b exp 0/0/0/ffff/1",
               state_out, count_digit, lives, best_time, ball_reset);
    end
    reset = 1'b0;
    step(1);
    start_game("rst");
    move_in = 4'b0101;
    step(1);
    start_btn = 1'b1;
    reset = 1'b1;
    step(1);
    checks++;
    if (state_out !== 3'd0 || move_out !== 4'd0 || timer_run !== 1'b0 || new_best !== 1'b0) begin
      errors++;
      $display("FAIL reset_play state=%0d move=%b run=%b nb=%b exp 0/0000/0/0",
               state_out, move_out, timer_run, new_best);
    end
    move_in = 4'b0000;
    reset = 1'b0;
    step(3);
    checks++;
    if (state_out !== 3'd0) begin
      errors++;
      $display("FAIL held_start state=%0d exp=0", state_out);
    end
    start_btn = 1'b0;
    step(1);
    start_btn = 1'b1;
    step(1);
    checks++;
    if (state_out !== 3'd1 || timer_clear !== 1'b1) begin
      errors++;
      $display("FAIL restart state=%0d clr=%b exp 1/1", state_out, timer_clear);
    end
    start_btn = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1'b1;
    start_btn = 1'b0;
    move_in = 4'b0000;
    won_the_game = 1'b0;
    hit_a_hole = 1'b0;
    elapsed = 16'd0;
    @(negedge clk);
    test_reset();
    test_start();
    test_move();
    test_holes();
    test_win();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
